// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction controller.
// SPI_LSB_FIRST_EN (optional define) selects LSB-first bit order in spi_txn_ctrl.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} spi_state_t;

   localparam int SPI_MAXLEN_DEF = 16;

   function automatic int spi_len_w(input int maxlen);
      return $clog2(maxlen) + 1;
   endfunction

   localparam int SPI_LEN_W = spi_len_w(SPI_MAXLEN_DEF);
   typedef logic [SPI_LEN_W-1:0] spi_len_t;

   // Mode 0: spi_clk idles low, data sampled on rising edge.
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   localparam int TMR_W = 8;

endpackage

// File: rtl/spi_edge_det.sv
// Registers the divider's spi_clk and emits single-cycle rise/fall pulses.
module spi_edge_det
   import spi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic spi_clk,
   output logic rise,
   output logic fall
);

   logic sclk_q;

   always_ff @(posedge clk) begin
      if (rst) sclk_q <= CPOL;
      else     sclk_q <= spi_clk;
   end

   assign rise = spi_clk & ~sclk_q;
   assign fall = ~spi_clk & sclk_q;

endmodule

// File: rtl/spi_txn_ctrl.sv
// SPI mode-0 transaction controller: owns cs_n, drives the divider, shifts MOSI/MISO.
// Define SPI_LSB_FIRST_EN for LSB-first transmit/receive order (default MSB-first).
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// SETUP | cs_n low, counting CS_SETUP cycles before start
// SHIFT | start high, bits move on spi_clk edges
// HOLD  | start low, counting CS_HOLD cycles before cs_n rises
// RESP  | rsp_valid held until consumer takes the word
module spi_txn_ctrl
   import spi_pkg::*;
#(
   parameter int SPI_MAXLEN = SPI_MAXLEN_DEF,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [SPI_MAXLEN-1:0]        req_data,
   input  logic [$clog2(SPI_MAXLEN):0]  req_len,
   input  logic                         spi_clk,
   output logic                         start,
   output logic [$clog2(SPI_MAXLEN):0]  n_pulses,
   output logic                         cs_n,
   output logic                         mosi,
   input  logic                         miso,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [SPI_MAXLEN-1:0]        rsp_data,
   output logic                         busy
);

   localparam int            LW       = spi_len_w(SPI_MAXLEN);
   localparam logic [LW-1:0] MAXLEN_L = LW'(SPI_MAXLEN);

   spi_state_t              state;
   logic [LW-1:0]           eff_len, bit_cnt, req_eff;
   logic [SPI_MAXLEN-1:0]   tx_sh, rx_sh;
   logic [SPI_MAXLEN-1:0]   tx_align, tx_shift, rx_shift, rx_just;
   logic [TMR_W-1:0]        tmr;
   logic                    tx_first, tx_next;
   logic                    rise, fall;

   spi_edge_det u_edge_det (
      .clk     (clk),
      .rst     (rst),
      .spi_clk (spi_clk),
      .rise    (rise),
      .fall    (fall)
   );

   always_comb begin
      req_eff = (req_len > MAXLEN_L) ? MAXLEN_L : req_len;
`ifdef SPI_LSB_FIRST_EN
      tx_align = req_data;
      tx_first = req_data[0];
      tx_shift = tx_sh >> 1;
      tx_next  = tx_shift[0];
      rx_shift = {miso, rx_sh[SPI_MAXLEN-1:1]};
      rx_just  = rx_sh >> (MAXLEN_L - eff_len);
`else
      // Left-align the word so the first bit to send always sits at the top.
      tx_align = req_data << (MAXLEN_L - req_eff);
      tx_first = tx_align[SPI_MAXLEN-1];
      tx_shift = tx_sh << 1;
      tx_next  = tx_shift[SPI_MAXLEN-1];
      rx_shift = {rx_sh[SPI_MAXLEN-2:0], miso};
      rx_just  = rx_sh;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         busy      <= 1'b0;
         cs_n      <= 1'b1;
         start     <= 1'b0;
         mosi      <= 1'b0;
         n_pulses  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         eff_len   <= '0;
         bit_cnt   <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         tmr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  eff_len   <= req_eff;
                  n_pulses  <= req_eff;
                  tx_sh     <= tx_align;
                  rx_sh     <= '0;
                  bit_cnt   <= '0;
                  if (req_eff == '0) begin
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     cs_n  <= 1'b0;
                     mosi  <= tx_first;
                     tmr   <= TMR_W'(CS_SETUP - 1);
                     state <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (tmr == '0) begin
                  start <= 1'b1;
                  state <= SHIFT;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            SHIFT: begin
               if (rise) begin
                  rx_sh   <= rx_shift;
                  bit_cnt <= bit_cnt + LW'(1);
               end else if (fall) begin
                  if (bit_cnt == eff_len) begin
                     start <= 1'b0;
                     mosi  <= 1'b0;
                     tmr   <= TMR_W'(CS_HOLD - 1);
                     state <= HOLD;
                  end else begin
                     tx_sh <= tx_shift;
                     mosi  <= tx_next;
                  end
               end
            end
            HOLD: begin
               if (tmr == '0) begin
                  cs_n      <= 1'b1;
                  rsp_data  <= rx_just;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
